// File: rtl/flash_erase_pkg.sv
// Shared flash bus timing, command codes and state types.
// Imported by the erase sequencer and the bus-cycle engine.
package flash_erase_pkg;

  localparam logic [7:0] T_RST  = 8'd8;
  localparam logic [7:0] T_VLVH = 8'd2;
  localparam logic [7:0] T_DVWH = 8'd2;
  localparam logic [7:0] T_WLWH = 8'd3;
  localparam logic [7:0] T_WHWL = 8'd2;
  localparam logic [7:0] T_GLQV = 8'd3;
  localparam logic [7:0] T_EHEL = 8'd2;
  localparam logic [7:0] T_HOLD = 8'd20;

  localparam logic [15:0] CMD_SETUP = 16'h0020;
  localparam logic [15:0] CMD_CONF  = 16'h00D0;
  localparam logic [15:0] CMD_CLRSR = 16'h0050;
  localparam logic [15:0] CMD_RDARR = 16'h00FF;

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_WAIT_RST,
    S_SETUP, S_CONFIRM, S_POLL,
    S_CHECK, S_CLR_SR, S_RD_ARRAY,
    S_FINISH
  } er_state_e;

  typedef enum logic [2:0] {
    B_IDLE, B_ADDR, B_WSTB, B_WDAT,
    B_WEND, B_WREC, B_OE, B_REC
  } bus_state_e;

  function automatic logic [3:0] sr_bits(
    input logic [15:0] sr
  );
    return {sr[7], sr[5], sr[3], sr[1]};
  endfunction

endpackage

// File: rtl/flash_erase_buscyc.sv
// flash_buscyc: one flash read or write bus cycle per start pulse.
// start/wr/addr/wdata in; done pulse + rdata out; drives the flash bus.
module flash_buscyc
  import flash_erase_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        wr,
  input  logic [24:0] addr,
  input  logic [15:0] wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic [24:0] A,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic        dqe,
  output logic        oe,
  output logic        ce,
  output logic        we,
  output logic        adv
);

  bus_state_e  st_q;
  logic [7:0]  cnt_q;
  logic        wr_q;
  logic [15:0] wd_q;
  logic        done_q;
  logic [15:0] rd_q;
  logic [24:0] a_q;
  logic [15:0] dq_q;
  logic        dqe_q, oe_q, ce_q, we_q, adv_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= B_IDLE;
      cnt_q  <= '0;
      wr_q   <= 1'b0;
      wd_q   <= '0;
      done_q <= 1'b0;
      rd_q   <= '0;
      a_q    <= '0;
      dq_q   <= '0;
      dqe_q  <= 1'b0;
      oe_q   <= 1'b1;
      ce_q   <= 1'b1;
      we_q   <= 1'b1;
      adv_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        B_IDLE: if (start) begin
          st_q  <= B_ADDR;
          cnt_q <= T_VLVH - 8'd1;
          wr_q  <= wr;
          wd_q  <= wdata;
          a_q   <= addr;
          ce_q  <= 1'b0;
          adv_q <= 1'b0;
        end
        B_ADDR: if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else begin
          adv_q <= 1'b1;
          if (wr_q) begin
            st_q  <= B_WSTB;
            we_q  <= 1'b0;
            cnt_q <= T_DVWH - 8'd1;
          end else begin
            st_q  <= B_OE;
            oe_q  <= 1'b0;
            cnt_q <= T_GLQV - 8'd1;
          end
        end
        B_WSTB: if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else begin
          st_q  <= B_WDAT;
          dq_q  <= wd_q;
          dqe_q <= 1'b1;
          cnt_q <= T_WLWH - 8'd1;
        end
        B_WDAT: if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else begin
          st_q <= B_WEND;
          we_q <= 1'b1;
          ce_q <= 1'b1;
        end
        B_WEND: begin
          st_q  <= B_WREC;
          dqe_q <= 1'b0;
          dq_q  <= '0;
          a_q   <= '0;
          cnt_q <= T_WHWL - 8'd1;
        end
        B_WREC: if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else begin
          st_q   <= B_IDLE;
          done_q <= 1'b1;
        end
        // dq_i is taken on the final cycle of the OE phase
        B_OE: if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else begin
          st_q  <= B_REC;
          rd_q  <= dq_i;
          oe_q  <= 1'b1;
          ce_q  <= 1'b1;
          cnt_q <= T_EHEL - 8'd1;
        end
        B_REC: if (cnt_q != 8'd0) begin
          cnt_q <= cnt_q - 8'd1;
        end else begin
          st_q   <= B_IDLE;
          a_q    <= '0;
          done_q <= 1'b1;
        end
        default: st_q <= B_IDLE;
      endcase
    end
  end

  assign done  = done_q;
  assign rdata = rd_q;
  assign A     = a_q;
  assign dq_o  = dq_q;
  assign dqe   = dqe_q;
  assign oe    = oe_q;
  assign ce    = ce_q;
  assign we    = we_q;
  assign adv   = adv_q;

endmodule

// File: rtl/flash_erase.sv
// flash_erase: multi-block erase sequencer with status polling.
// erase_en/block_addr/block_cnt in; erase_done/err/code out; flash bus.
module flash_erase
  import flash_erase_pkg::*;
#(
  parameter logic [24:0] BLOCK_STRIDE = 25'h20000,
  parameter logic [23:0] POLL_MAX     = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        erase_en,
  input  logic [24:0] block_addr,
  input  logic [9:0]  block_cnt,
  output logic        erase_done,
  output logic        erase_err,
  output logic [3:0]  err_code,
  output logic [24:0] A,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic        dqe,
  output logic        oe,
  output logic        ce,
  output logic        we,
  output logic        adv,
  output logic        wp,
  input  logic        wd,
  output logic        rst_f
);

  localparam logic [23:0] P_LAST = POLL_MAX - 24'd1;

  er_state_e   st_q;
  logic [24:0] cur_q;
  logic [9:0]  last_q, blk_q;
  logic [23:0] poll_q;
  logic [7:0]  wait_q;
  logic [3:0]  sr_q, code_q;
  logic        lat_q, err_q, done_q, rstf_q;
  logic        go_q, busy_q, bwr_q;
  logic [15:0] bwd_q;
  logic        b_done;
  logic [15:0] b_rd;
  logic        unused_in;

  assign unused_in = ^{wd, b_rd[15:8], b_rd[6],
                       b_rd[4], b_rd[2], b_rd[0]};

  flash_buscyc u_bus (
    .clk   (clk),
    .rst_n (rst_n),
    .start (go_q),
    .wr    (bwr_q),
    .addr  (cur_q),
    .wdata (bwd_q),
    .done  (b_done),
    .rdata (b_rd),
    .A     (A),
    .dq_i  (dq_i),
    .dq_o  (dq_o),
    .dqe   (dqe),
    .oe    (oe),
    .ce    (ce),
    .we    (we),
    .adv   (adv)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      cur_q  <= '0;
      last_q <= '0;
      blk_q  <= '0;
      poll_q <= '0;
      wait_q <= '0;
      sr_q   <= '0;
      code_q <= '0;
      lat_q  <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      rstf_q <= 1'b0;
      go_q   <= 1'b0;
      busy_q <= 1'b0;
      bwr_q  <= 1'b0;
      bwd_q  <= '0;
    end else begin
      rstf_q <= 1'b1;
      go_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (st_q)
        S_IDLE: if (erase_en) st_q <= S_LATCH;
        S_LATCH: begin
          cur_q  <= block_addr;
          last_q <= block_cnt;
          blk_q  <= '0;
          poll_q <= '0;
          err_q  <= 1'b0;
          lat_q  <= 1'b0;
          code_q <= '0;
          wait_q <= T_RST - 8'd1;
          st_q   <= S_WAIT_RST;
        end
        S_WAIT_RST: if (wait_q != 8'd0) begin
          wait_q <= wait_q - 8'd1;
        end else begin
          st_q <= S_SETUP;
        end
        S_SETUP: if (!busy_q) begin
          go_q   <= 1'b1;
          busy_q <= 1'b1;
          bwr_q  <= 1'b1;
          bwd_q  <= CMD_SETUP;
        end else if (b_done) begin
          busy_q <= 1'b0;
          st_q   <= S_CONFIRM;
        end
        S_CONFIRM: if (!busy_q) begin
          go_q   <= 1'b1;
          busy_q <= 1'b1;
          bwr_q  <= 1'b1;
          bwd_q  <= CMD_CONF;
        end else if (b_done) begin
          busy_q <= 1'b0;
          st_q   <= S_POLL;
        end
        S_POLL: if (!busy_q) begin
          go_q   <= 1'b1;
          busy_q <= 1'b1;
          bwr_q  <= 1'b0;
        end else if (b_done) begin
          busy_q <= 1'b0;
          sr_q   <= sr_bits(b_rd);
          st_q   <= S_CHECK;
        end
        // sr_q = {SR7, SR5, SR3, SR1}
        S_CHECK: if (!sr_q[3]) begin
          if (poll_q == P_LAST) begin
            lat_q  <= 1'b1;
            code_q <= 4'b1000;
            st_q   <= S_CLR_SR;
          end else begin
            poll_q <= poll_q + 24'd1;
            st_q   <= S_POLL;
          end
        end else if (sr_q[2:0] != 3'b000) begin
          lat_q  <= 1'b1;
          code_q <= {1'b0, sr_q[2:0]};
          st_q   <= S_CLR_SR;
        end else if (blk_q == last_q) begin
          st_q <= S_RD_ARRAY;
        end else begin
          cur_q  <= cur_q + BLOCK_STRIDE;
          blk_q  <= blk_q + 10'd1;
          poll_q <= '0;
          st_q   <= S_SETUP;
        end
        S_CLR_SR: if (!busy_q) begin
          go_q   <= 1'b1;
          busy_q <= 1'b1;
          bwr_q  <= 1'b1;
          bwd_q  <= CMD_CLRSR;
        end else if (b_done) begin
          busy_q <= 1'b0;
          st_q   <= S_RD_ARRAY;
        end
        S_RD_ARRAY: if (!busy_q) begin
          go_q   <= 1'b1;
          busy_q <= 1'b1;
          bwr_q  <= 1'b1;
          bwd_q  <= CMD_RDARR;
        end else if (b_done) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          err_q  <= lat_q;
          wait_q <= T_HOLD - 8'd1;
          st_q   <= S_FINISH;
        end
        S_FINISH: if (wait_q != 8'd0) begin
          wait_q <= wait_q - 8'd1;
        end else begin
          st_q <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign erase_done = done_q;
  assign erase_err  = err_q;
  assign err_code   = code_q;
  assign rst_f      = rstf_q;
  assign wp         = 1'b1;

endmodule

// File: tb/tb_flash_erase.sv
// Scoreboard bench for flash_erase with a behavioural flash SR model.
// Expected bus events are queued at stimulus time, popped as observed.
module tb_flash_erase;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        erase_en = 1'b0;
  logic        wd = 1'b0;
  logic [24:0] block_addr = '0;
  logic [9:0]  block_cnt = '0;
  logic        erase_done, erase_err;
  logic [3:0]  err_code;
  logic [24:0] A;
  logic [15:0] dq_i, dq_o;
  logic        dqe, oe, ce, we, adv, wp, rst_f;

  localparam logic [3:0] K_W = 4'd1;
  localparam logic [3:0] K_R = 4'd2;
  localparam logic [3:0] K_D = 4'd3;

  int npass = 0;
  int ntot = 0;
  int done_n = 0;
  int poll_n = 0;
  int ready_at = 0;
  logic [15:0] ready_sr = '0;
  logic [15:0] sr_drv = '0;
  logic we_p = 1'b1;
  logic oe_p = 1'b1;
  logic [47:0] exp_q[$];

  always #5 clk = ~clk;

  assign dq_i = oe ? 16'h0 : sr_drv;

  flash_erase #(.POLL_MAX(24'd16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .erase_en   (erase_en),
    .block_addr (block_addr),
    .block_cnt  (block_cnt),
    .erase_done (erase_done),
    .erase_err  (erase_err),
    .err_code   (err_code),
    .A          (A),
    .dq_i       (dq_i),
    .dq_o       (dq_o),
    .dqe        (dqe),
    .oe         (oe),
    .ce         (ce),
    .we         (we),
    .adv        (adv),
    .wp         (wp),
    .wd         (wd),
    .rst_f      (rst_f)
  );

  task automatic chk(input string tag,
                     input logic [47:0] obs,
                     input logic [47:0] exp);
    ntot++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %h want %h",
                  tag, obs, exp);
  endtask

  function automatic logic [47:0] ev(
    input logic [3:0] k,
    input logic [24:0] a,
    input logic [15:0] d
  );
    return {k, 3'b000, a, d};
  endfunction

  task automatic got(input logic [47:0] e);
    logic [47:0] x;
    string t;
    if (exp_q.size() == 0) begin
      chk("extra", e, 48'h0);
      return;
    end
    x = exp_q.pop_front();
    case (x[47:44])
      K_W: t = "wr";
      K_R: t = "rd";
      default: t = "done";
    endcase
    chk(t, e, x);
  endtask

  task automatic tick();
    @(negedge clk);
    wd = 1'($urandom);
    if (we_p === 1'b0 && we === 1'b1) begin
      got(ev(K_W, A, dq_o));
      if (dq_o == 16'h00D0) poll_n = 0;
    end
    if (oe_p === 1'b1 && oe === 1'b0) begin
      got(ev(K_R, A, 16'h0));
      poll_n++;
      sr_drv = (ready_at != 0 && poll_n >= ready_at)
               ? ready_sr : 16'h0;
    end
    if (erase_done === 1'b1) begin
      got(ev(K_D, 25'h0,
             {11'h0, erase_err, err_code}));
      done_n++;
    end
    we_p = we;
    oe_p = oe;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic exp_blk(input logic [24:0] a,
                         input int nr);
    exp_q.push_back(ev(K_W, a, 16'h0020));
    exp_q.push_back(ev(K_W, a, 16'h00D0));
    repeat (nr) exp_q.push_back(ev(K_R, a, 16'h0));
  endtask

  task automatic exp_end(input logic [24:0] a,
                         input logic err,
                         input logic [3:0] code);
    if (err) exp_q.push_back(ev(K_W, a, 16'h0050));
    exp_q.push_back(ev(K_W, a, 16'h00FF));
    exp_q.push_back(ev(K_D, 25'h0,
                       {11'h0, err, code}));
  endtask

  task automatic setup(input logic [24:0] a,
                       input logic [9:0] n,
                       input int ra,
                       input logic [15:0] sr);
    block_addr = a;
    block_cnt = n;
    ready_at = ra;
    ready_sr = sr;
  endtask

  task automatic start(input logic [24:0] a,
                       input logic [9:0] n,
                       input int ra,
                       input logic [15:0] sr);
    setup(a, n, ra, sr);
    erase_en = 1'b1;
    tick();
    erase_en = 1'b0;
    tick();
  endtask

  task automatic run_wait(input int nd,
                          input bit wiggle);
    int s;
    int c;
    s = done_n;
    c = 0;
    while (done_n < s + nd && c < 6000) begin
      if (wiggle) erase_en = (c % 7 == 3);
      tick();
      c++;
    end
    if (wiggle) erase_en = 1'b0;
    chk("tmo", 48'(c < 6000), 48'h1);
  endtask

  task automatic drain(input string tag);
    idle(25);
    chk(tag, 48'(exp_q.size()), 48'h0);
  endtask

  initial begin
    int c;
    idle(3);
    chk("rst_A", 48'(A), 48'h0);
    chk("rst_dqe", 48'(dqe), 48'h0);
    chk("rst_dq", 48'(dq_o), 48'h0);
    chk("rst_oe", 48'(oe), 48'h1);
    chk("rst_ce", 48'(ce), 48'h1);
    chk("rst_we", 48'(we), 48'h1);
    chk("rst_adv", 48'(adv), 48'h1);
    chk("rst_wp", 48'(wp), 48'h1);
    chk("rst_rstf", 48'(rst_f), 48'h0);
    chk("rst_done", 48'(erase_done), 48'h0);
    chk("rst_err", 48'(erase_err), 48'h0);
    chk("rst_code", 48'(err_code), 48'h0);
    rst_n = 1'b1;
    idle(3);
    chk("idle_rstf", 48'(rst_f), 48'h1);

    exp_blk(25'h0, 3);
    exp_end(25'h0, 1'b0, 4'h0);
    start(25'h0, 10'd0, 3, 16'h0080);
    run_wait(1, 1'b1);
    chk("t1_err", 48'(erase_err), 48'h0);
    drain("t1_left");

    exp_blk(25'h1000000, 1);
    exp_blk(25'h1020000, 1);
    exp_blk(25'h1040000, 1);
    exp_end(25'h1040000, 1'b0, 4'h0);
    start(25'h1000000, 10'd2, 1, 16'h0080);
    run_wait(1, 1'b0);
    drain("t2_left");

    exp_blk(25'h1FE0000, 2);
    exp_blk(25'h0000000, 2);
    exp_end(25'h0000000, 1'b0, 4'h0);
    start(25'h1FE0000, 10'd1, 2, 16'h0080);
    run_wait(1, 1'b0);
    drain("wrap_left");

    exp_blk(25'h0060000, 1);
    exp_end(25'h0060000, 1'b1, 4'b0100);
    start(25'h0060000, 10'd3, 1, 16'h00A0);
    run_wait(1, 1'b0);
    drain("t3_left");
    chk("t3_err_hold", 48'(erase_err), 48'h1);
    chk("t3_code_hold", 48'(err_code), 48'h4);

    exp_blk(25'h0000123, 16);
    exp_end(25'h0000123, 1'b1, 4'b1000);
    start(25'h0000123, 10'd0, 0, 16'h0000);
    chk("t4_err_clr", 48'(erase_err), 48'h0);
    run_wait(1, 1'b0);
    drain("t4_left");

    exp_blk(25'h0ABCDE0, 2);
    exp_end(25'h0ABCDE0, 1'b1, 4'b0011);
    start(25'h0ABCDE0, 10'd5, 2, 16'h008A);
    run_wait(1, 1'b0);
    drain("t5_left");

    exp_blk(25'h0100000, 1);
    start(25'h0100000, 10'd0, 0, 16'h0000);
    c = 0;
    while (oe !== 1'b0 && c < 500) begin
      tick();
      c++;
    end
    chk("t6_poll", 48'(c < 500), 48'h1);
    rst_n = 1'b0;
    tick();
    chk("t6_oe", 48'(oe), 48'h1);
    chk("t6_ce", 48'(ce), 48'h1);
    chk("t6_we", 48'(we), 48'h1);
    chk("t6_adv", 48'(adv), 48'h1);
    chk("t6_rstf", 48'(rst_f), 48'h0);
    chk("t6_done", 48'(erase_done), 48'h0);
    rst_n = 1'b1;
    idle(40);
    chk("t6_left", 48'(exp_q.size()), 48'h0);

    exp_blk(25'h0800000, 2);
    exp_end(25'h0800000, 1'b0, 4'h0);
    exp_blk(25'h0800000, 2);
    exp_end(25'h0800000, 1'b0, 4'h0);
    setup(25'h0800000, 10'd0, 2, 16'h0080);
    erase_en = 1'b1;
    run_wait(2, 1'b0);
    erase_en = 1'b0;
    drain("t7_left");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
